muldiv_seq: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles, one bit per cycle, using a single shared adder/subtractor. It raises busy so the pipeline can stall MFHI/MFLO and further mul/div issue. It sits beside the single-cycle ALU in EX and handles the operations that ALU does not implement.

---
 rtl/muldiv_seq.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer that owns the HI/LO pair.
// Executes MULT, MULTU, DIV and DIVU at one bit per cycle through a single
// shared WIDTH+1 bit adder/subtractor. Latency from an accepted start to the
// done pulse is WIDTH+2 cycles (WIDTH iterations, one fix-up, one done).
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset    synchronous active-high reset
//   start    begin an operation (accepted only in IDLE or DONE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val   multiplicand / dividend
//   rt_val   multiplier / divisor
//   mthi     write wr_data into HI (IDLE/DONE only, start has priority)
//   mtlo     write wr_data into LO (IDLE/DONE only, start has priority)
//   wr_data  data for mthi/mtlo
//   busy     operation in progress (ITER or FIX)
//   done     one-cycle pulse, HI/LO hold the new result
//   hi, lo   HI and LO registers
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + ONE_W;
  endfunction

  // Two's-complement negation of a 2*WIDTH-bit value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + ONE_2W;
  endfunction

  state_t             state_r, state_next_s;
  logic               busy_r, done_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;          // operand magnitudes (or raw for unsigned)
  logic               sign_a_r, sign_b_r;
  logic               div_zero_r;
  logic [2*WIDTH-1:0] acc_r;             // mul: {partial, multiplier}; div: {rem, quot}
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               idle_like_s;
  logic               is_div_s, is_signed_s;
  logic               in_signed_s, rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
  logic [WIDTH:0]     add_x_s, add_y_s, sum_s;
  logic               add_cin_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  assign idle_like_s = (state_r == IDLE) || (state_r == DONE);
  assign is_div_s    = op_r[1];
  assign is_signed_s = ~op_r[0];

  // Operand preparation for a new operation: magnitudes for signed ops.
  always_comb begin
    in_signed_s = ~op[0];
    rs_neg_s    = in_signed_s & rs_val[WIDTH-1];
    rt_neg_s    = in_signed_s & rt_val[WIDTH-1];
    if (rs_neg_s) begin
      rs_mag_s = neg_w(rs_val);
    end else begin
      rs_mag_s = rs_val;
    end
    if (rt_neg_s) begin
      rt_mag_s = neg_w(rt_val);
    end else begin
      rt_mag_s = rt_val;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ITER;
        end else begin
          state_next_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = FIX;
        end else begin
          state_next_s = ITER;
        end
      end
      FIX:  state_next_s = DONE;
      DONE: begin
        if (start) begin
          state_next_s = ITER;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ITER) || (state_next_s == FIX);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Shared adder: shift-add for multiply, restoring trial subtract for divide.
  // A negative divide difference shows up as sum_s[WIDTH] set (borrow).
  always_comb begin
    add_x_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    add_y_s   = {1'b0, ZERO_W};
    add_cin_s = 1'b0;
    if (is_div_s) begin
      add_x_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      add_y_s   = ~{1'b0, b_r};
      add_cin_s = 1'b1;
    end else begin
      add_x_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      if (acc_r[0]) begin
        add_y_s = {1'b0, a_r};
      end else begin
        add_y_s = {1'b0, ZERO_W};
      end
      add_cin_s = 1'b0;
    end
    sum_s = add_x_s + add_y_s + {{WIDTH{1'b0}}, add_cin_s};
    if (is_div_s) begin
      if (sum_s[WIDTH]) begin
        acc_step_s = {add_x_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_step_s = {sum_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the finished magnitude result. Divide by zero returns
  // all-ones quotient and the original dividend; sign_a_r is only set for
  // signed ops, so negating the magnitude rebuilds rs_val in both cases.
  always_comb begin
    if (is_signed_s && (sign_a_r ^ sign_b_r)) begin
      prod_s = neg_2w(acc_r);
      quot_s = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[WIDTH-1:0];
    end
    if (is_signed_s && sign_a_r) begin
      rem_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
    if (!is_div_s) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (div_zero_r) begin
      if (sign_a_r) begin
        res_hi_s = neg_w(a_r);
      end else begin
        res_hi_s = a_r;
      end
      res_lo_s = ONES_W;
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
    end
  end

  // Datapath: operand latch, iteration, HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= 2'b00;
      a_r        <= ZERO_W;
      b_r        <= ZERO_W;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
      acc_r      <= {ZERO_W, ZERO_W};
      cnt_r      <= {CW{1'b0}};
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
    end else begin
      case (state_r)
        ITER: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        IDLE, DONE: begin
          if (start) begin
            op_r       <= op;
            a_r        <= rs_mag_s;
            b_r        <= rt_mag_s;
            sign_a_r   <= rs_neg_s;
            sign_b_r   <= rt_neg_s;
            div_zero_r <= (rt_val == ZERO_W);
            cnt_r      <= {CW{1'b0}};
            // Divide shifts the dividend out of the low half; multiply
            // shifts the multiplier out of it.
            if (op[1]) begin
              acc_r <= {ZERO_W, rs_mag_s};
            end else begin
              acc_r <= {ZERO_W, rt_mag_s};
            end
          end else begin
            if (mthi) begin
              hi_r <= wr_data;
            end
            if (mtlo) begin
              lo_r <= wr_data;
            end
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // idle_like_s is kept for readability of the accept condition above.
  logic unused_s;
  assign unused_s = idle_like_s;

endmodule
